// File: rtl/oled_spi_tx.sv
// oled_spi_tx: MSB-first SPI serializer for the PmodOLED with D/C line and CS guard time.
module oled_spi_tx #(
    parameter int CBITS = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wr,
    input  logic        i_dbit,
    input  logic [31:0] i_word,
    input  logic [1:0]  i_len,
    output logic        o_busy,
    output logic        o_sck,
    output logic        o_cs_n,
    output logic        o_mosi,
    output logic        o_dbit
);
    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;
    state_t state_q, state_d;
    logic [CBITS:0] div_q, div_d, div_inc;
    logic [4:0] bit_q, bit_d;
    logic [31:0] sr_q, sr_d;
    logic [1:0] len_q, len_d;
    logic dbit_q, dbit_d, busy_q, busy_d, sck_q, sck_d, cs_n_q, cs_n_d, mosi_q, mosi_d;
    logic half_end, last_bit;
    // In SHIFT the divider MSB is the SCK phase; the low bits wrap every half-period.
    assign div_inc  = div_q + {{CBITS{1'b0}}, 1'b1};
    assign half_end = &div_q[CBITS-1:0];
    assign last_bit = bit_q == {len_q, 3'b111};
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            len_q   <= '0;
            dbit_q  <= 1'b0;
            busy_q  <= 1'b0;
            sck_q   <= 1'b1;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            len_q   <= len_d;
            dbit_q  <= dbit_d;
            busy_q  <= busy_d;
            sck_q   <= sck_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
        end
    end
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        len_d   = len_q;
        dbit_d  = dbit_q;
        case (state_q)
            IDLE: if (i_wr) begin
                state_d = LEAD;
                div_d   = '0;
                bit_d   = '0;
                sr_d    = i_word;
                len_d   = i_len;
                dbit_d  = i_dbit;
            end
            LEAD: begin
                div_d   = half_end ? '0 : div_inc;
                state_d = half_end ? SHIFT : LEAD;
            end
            SHIFT: begin
                div_d = div_inc;
                if (&div_q) begin
                    sr_d    = {sr_q[30:0], 1'b0};
                    bit_d   = last_bit ? bit_q : bit_q + 5'd1;
                    state_d = last_bit ? TRAIL : SHIFT;
                end
            end
            TRAIL: begin
                div_d   = half_end ? '0 : div_inc;
                state_d = half_end ? IDLE : TRAIL;
            end
        endcase
    end
    // Outputs are decoded from next state so every pin comes straight off a flop.
    always_comb begin
        busy_d = state_d != IDLE;
        cs_n_d = !(state_d == LEAD || state_d == SHIFT);
        sck_d  = state_d == SHIFT ? div_d[CBITS] : 1'b1;
        mosi_d = cs_n_d ? 1'b0 : sr_d[31];
    end
    assign o_busy = busy_q;
    assign o_sck  = sck_q;
    assign o_cs_n = cs_n_q;
    assign o_mosi = mosi_q;
    assign o_dbit = dbit_q;
endmodule
